// File: rtl/cpu_regfile_pkg.sv
// Shared widths, the PC read-through index and address/data types for the
// register file and its scoreboard.
package cpu_regfile_pkg;

    localparam int unsigned N          = 32;
    localparam int unsigned A          = 4;
    localparam int unsigned DEPTH      = 2 ** A;
    localparam int unsigned PC_REG_IDX = 15;

    typedef logic [A-1:0] reg_addr_t;
    typedef logic [N-1:0] reg_data_t;

    // Entry whose reads return the PC and whose writes/locks are dropped
    localparam reg_addr_t PC_REG = A'(PC_REG_IDX);

endpackage : cpu_regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode (lock) and
// cleared by writeback. Raises BUSY for a read port whose operand has an
// in-flight producer that is not being written back this very cycle.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_we, i_wa           writeback enable (active-low) and address
//   i_lock_en, i_lock_a  decode claims i_lock_a as pending
//   i_ra1, i_ra2         read addresses being checked
//   o_busy1, o_busy2     combinational hazard flags per read port
module regfile_scoreboard
    import cpu_regfile_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_we,
    input  logic      [A-1:0] i_wa,
    input  logic      i_lock_en,
    input  logic      [A-1:0] i_lock_a,
    input  logic      [A-1:0] i_ra1,
    input  logic      [A-1:0] i_ra2,
    output logic      o_busy1,
    output logic      o_busy2
);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_byp1;
    logic             w_byp2;

    // Clear first, then set, so a new producer on the same address wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (!i_we) begin
            w_pend_nxt[i_wa] = 1'b0;
        end
        if (i_lock_en && (i_lock_a != PC_REG)) begin
            w_pend_nxt[i_lock_a] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // A same-cycle writeback to the read address is forwarded, so no hazard
    always_comb begin
        w_byp1  = !i_we && (i_wa == i_ra1);
        w_byp2  = !i_we && (i_wa == i_ra2);
        o_busy1 = r_pend[i_ra1] && !w_byp1 && (i_ra1 != PC_REG);
        o_busy2 = r_pend[i_ra2] && !w_byp2 && (i_ra2 != PC_REG);
    end

endmodule : regfile_scoreboard

// File: rtl/register_file_sb.sv
// DEPTH x N register file with two combinational read ports, one synchronous
// write port (active-low enable), write-to-read bypass, PC read-through on
// PC_REG and a pending-write scoreboard driving STALL.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_we, i_wa, i_wd      writeback: enable (active-low), address, data
//   i_ra1/i_ra2           read addresses; o_rd1/o_rd2 combinational data
//   i_pc_in               value returned for reads of PC_REG
//   i_lock_en, i_lock_a   decode marks i_lock_a as pending-write
//   o_busy1/o_busy2       per-port unresolved pending write
//   o_stall               o_busy1 | o_busy2
module register_file_sb
    import cpu_regfile_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [A-1:0] i_wa,
    input  logic [N-1:0] i_wd,
    input  logic [A-1:0] i_ra1,
    input  logic [A-1:0] i_ra2,
    output logic [N-1:0] o_rd1,
    output logic [N-1:0] o_rd2,
    input  logic [N-1:0] i_pc_in,
    input  logic         i_lock_en,
    input  logic [A-1:0] i_lock_a,
    output logic         o_busy1,
    output logic         o_busy2,
    output logic         o_stall
);

    reg_data_t r_mem [DEPTH];
    logic      w_wr_en;

    assign w_wr_en = !i_we && (i_wa != PC_REG);

    // Storage: reset clears every entry; PC_REG is never written
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '{default: '0};
        end else if (w_wr_en) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read priority: PC read-through, then same-cycle bypass, then storage
    always_comb begin
        o_rd1 = r_mem[i_ra1];
        if (i_ra1 == PC_REG) begin
            o_rd1 = i_pc_in;
        end else if (!i_we && (i_wa == i_ra1)) begin
            o_rd1 = i_wd;
        end

        o_rd2 = r_mem[i_ra2];
        if (i_ra2 == PC_REG) begin
            o_rd2 = i_pc_in;
        end else if (!i_we && (i_wa == i_ra2)) begin
            o_rd2 = i_wd;
        end
    end

    regfile_scoreboard u_sb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (i_we),
        .i_wa      (i_wa),
        .i_lock_en (i_lock_en),
        .i_lock_a  (i_lock_a),
        .i_ra1     (i_ra1),
        .i_ra2     (i_ra2),
        .o_busy1   (o_busy1),
        .o_busy2   (o_busy2)
    );

    assign o_stall = o_busy1 | o_busy2;

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Table-driven check of register_file_sb: each record is one cycle of
// inputs plus the combinational outputs expected before that cycle's edge.
module tb_register_file_sb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc_in;
    logic        lock_en;
    logic [3:0]  lock_a;
    logic        busy1;
    logic        busy2;
    logic        stall;

    int checks = 0;
    int errors = 0;

    register_file_sb dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (we),
        .i_wa      (wa),
        .i_wd      (wd),
        .i_ra1     (ra1),
        .i_ra2     (ra2),
        .o_rd1     (rd1),
        .o_rd2     (rd2),
        .i_pc_in   (pc_in),
        .i_lock_en (lock_en),
        .i_lock_a  (lock_a),
        .o_busy1   (busy1),
        .o_busy2   (busy2),
        .o_stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] pc;
        logic        len;
        logic [3:0]  la;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_st;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        st;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    exp_t sbq [$];

    function automatic vec_t mk(
        input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
        input logic [3:0] r1, input logic [3:0] r2, input logic [31:0] p,
        input logic le, input logic [3:0] la,
        input logic [31:0] x1, input logic [31:0] x2,
        input logic b1, input logic b2, input logic st);
        vec_t v;
        v.rst = r;  v.we = w;  v.wa = a;  v.wd = d;
        v.ra1 = r1; v.ra2 = r2; v.pc = p; v.len = le; v.la = la;
        v.e_rd1 = x1; v.e_rd2 = x2; v.e_b1 = b1; v.e_b2 = b2; v.e_st = st;
        return v;
    endfunction

    task automatic chk32(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int idx,
                        input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive one record, queue its expectation, compare mid-cycle, then clock
    task automatic apply(input int idx);
        exp_t e;
        exp_t got;
        rst     = vecs[idx].rst;
        we      = vecs[idx].we;
        wa      = vecs[idx].wa;
        wd      = vecs[idx].wd;
        ra1     = vecs[idx].ra1;
        ra2     = vecs[idx].ra2;
        pc_in   = vecs[idx].pc;
        lock_en = vecs[idx].len;
        lock_a  = vecs[idx].la;
        e.idx = idx;
        e.rd1 = vecs[idx].e_rd1;
        e.rd2 = vecs[idx].e_rd2;
        e.b1  = vecs[idx].e_b1;
        e.b2  = vecs[idx].e_b2;
        e.st  = vecs[idx].e_st;
        sbq.push_back(e);
        #2;
        got = sbq.pop_front();
        chk32("rd1",   got.idx, rd1,   got.rd1);
        chk32("rd2",   got.idx, rd2,   got.rd2);
        chk1 ("busy1", got.idx, busy1, got.b1);
        chk1 ("busy2", got.idx, busy2, got.b2);
        chk1 ("stall", got.idx, stall, got.st);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rst we wa  wd            ra1 ra2 pc       le la   rd1           rd2           b1 b2 st
        vecs[0]  = mk(0, 0, 3,  32'hDEADBEEF, 3,  0,  32'h0,   0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 1, 0,  32'h0,        3,  3,  32'h0,   1, 4,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0,  32'h0,        3,  4,  32'h0,   0, 0,  32'h0,        32'h0,        0, 0, 0);
        vecs[3]  = mk(0, 0, 5,  32'h1234,     0,  5,  32'h0,   0, 0,  32'h0,        32'h1234,     0, 0, 0);
        vecs[4]  = mk(0, 1, 5,  32'hFFFF,     5,  5,  32'h0,   0, 0,  32'h1234,     32'h1234,     0, 0, 0);
        vecs[5]  = mk(0, 1, 0,  32'h0,        6,  5,  32'h0,   0, 0,  32'h0,        32'h1234,     0, 0, 0);
        vecs[6]  = mk(0, 0, 7,  32'hA5A5A5A5, 7,  5,  32'h0,   0, 0,  32'hA5A5A5A5, 32'h1234,     0, 0, 0);
        vecs[7]  = mk(0, 0, 15, 32'h55,       15, 7,  32'h100, 1, 15, 32'h100,      32'hA5A5A5A5, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0,  32'h0,        15, 15, 32'h100, 0, 0,  32'h100,      32'h100,      0, 0, 0);
        vecs[9]  = mk(0, 1, 0,  32'h0,        2,  15, 32'h200, 1, 2,  32'h0,        32'h200,      0, 0, 0);
        vecs[10] = mk(0, 1, 0,  32'h0,        2,  0,  32'h0,   0, 0,  32'h0,        32'h0,        1, 0, 1);
        vecs[11] = mk(0, 0, 2,  32'h22,       2,  2,  32'h0,   0, 0,  32'h22,       32'h22,       0, 0, 0);
        vecs[12] = mk(0, 1, 0,  32'h0,        2,  5,  32'h0,   0, 0,  32'h22,       32'h1234,     0, 0, 0);
        vecs[13] = mk(0, 1, 0,  32'h0,        4,  2,  32'h0,   1, 4,  32'h0,        32'h22,       0, 0, 0);
        vecs[14] = mk(0, 1, 0,  32'h0,        4,  4,  32'h0,   0, 0,  32'h0,        32'h0,        1, 1, 1);
        vecs[15] = mk(0, 0, 4,  32'h44,       4,  0,  32'h0,   1, 4,  32'h44,       32'h0,        0, 0, 0);
        vecs[16] = mk(0, 1, 0,  32'h0,        4,  4,  32'h0,   0, 0,  32'h44,       32'h44,       1, 1, 1);
        vecs[17] = mk(0, 0, 4,  32'h45,       6,  4,  32'h0,   1, 6,  32'h0,        32'h45,       0, 0, 0);
        vecs[18] = mk(0, 1, 0,  32'h0,        6,  4,  32'h0,   0, 0,  32'h0,        32'h45,       1, 0, 1);
        vecs[19] = mk(1, 1, 0,  32'h0,        6,  0,  32'h0,   1, 8,  32'h0,        32'h0,        1, 0, 1);
        vecs[20] = mk(0, 1, 0,  32'h0,        6,  4,  32'h0,   0, 0,  32'h0,        32'h0,        0, 0, 0);

        // Initial reset so storage and pending bits start known
        rst = 1'b1; we = 1'b1; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        pc_in = '0; lock_en = 1'b0; lock_a = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk32("rst_rd1",   -1, rd1,   32'h0);
        chk1 ("rst_stall", -1, stall, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            apply(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file_sb
